// File: rtl/sprite_overlay_compositor.sv
// Composites NUM_SPR ROM-backed rectangular sprites over a background colour for a VGA stream.
// Optional macro OVL_COLORKEY_EN: sprite pixels equal to KEY_RGB are treated as transparent.
module sprite_overlay_compositor #(
  parameter int unsigned NUM_SPR    = 2,
  parameter int unsigned SPR_W      = 120,
  parameter int unsigned SPR_H      = 120,
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned BLINK_LOG2 = 5,
  parameter logic [11:0] KEY_RGB    = 12'hF0F
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_pix_ce,
  input  logic [X_W-1:0]            i_x,
  input  logic [Y_W-1:0]            i_y,
  input  logic                      i_de,
  input  logic [NUM_SPR-1:0]        i_spr_en,
  input  logic [NUM_SPR-1:0]        i_spr_blink,
  input  logic [NUM_SPR*X_W-1:0]    i_spr_x0,
  input  logic [NUM_SPR*Y_W-1:0]    i_spr_y0,
  input  logic [11:0]               i_bg_rgb,
  output logic [NUM_SPR*ADDR_W-1:0] o_rom_addr,
  input  logic [NUM_SPR*12-1:0]     i_rom_data,
  output logic [3:0]                o_red,
  output logic [3:0]                o_green,
  output logic [3:0]                o_blue,
  output logic                      o_de
);

  localparam logic [X_W:0]      SprWX = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0]      SprHY = (Y_W+1)'(SPR_H);
  localparam logic [ADDR_W-1:0] SprWA = ADDR_W'(SPR_W);

  // Per-frame shadow copies of the sprite programming
  logic [NUM_SPR-1:0]     sh_en_q, sh_blink_q;
  logic [NUM_SPR*X_W-1:0] sh_x0_q;
  logic [NUM_SPR*Y_W-1:0] sh_y0_q;
  logic [BLINK_LOG2-1:0]  frame_cnt_q;

  logic [NUM_SPR*ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [NUM_SPR-1:0]        vis, hit, hit0_q, hit1_q, opaque;
  logic                      de0_q, de1_q, de_q;
  logic [11:0]               sel_rgb, rgb_q;
  logic                      frame_start;

  assign frame_start = i_pix_ce && (i_x == '0) && (i_y == '0);

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [X_W:0]   x_lo, x_hi, x_e;
    logic [Y_W:0]   y_lo, y_hi, y_e;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    // One extra bit so windows straddling the coordinate maximum clip instead of wrapping
    assign x_e  = {1'b0, i_x};
    assign y_e  = {1'b0, i_y};
    assign x_lo = {1'b0, sh_x0_q[g*X_W +: X_W]};
    assign y_lo = {1'b0, sh_y0_q[g*Y_W +: Y_W]};
    assign x_hi = x_lo + SprWX;
    assign y_hi = y_lo + SprHY;
    assign dx   = i_x - sh_x0_q[g*X_W +: X_W];
    assign dy   = i_y - sh_y0_q[g*Y_W +: Y_W];

    assign vis[g] = sh_en_q[g] & ~(sh_blink_q[g] & frame_cnt_q[BLINK_LOG2-1]);
    assign hit[g] = vis[g] & i_de & (x_e >= x_lo) & (x_e < x_hi) & (y_e >= y_lo) & (y_e < y_hi);
    assign rom_addr_d[g*ADDR_W +: ADDR_W] =
        hit[g] ? (ADDR_W'(dy) * SprWA + ADDR_W'(dx)) : '0;
  end

`ifdef OVL_COLORKEY_EN
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_key
    assign opaque[g] = (i_rom_data[g*12 +: 12] != KEY_RGB);
  end
`else
  logic [11:0] unused_key;
  assign unused_key = KEY_RGB;
  assign opaque     = '1;
`endif

  // Descending scan so the lowest-index opaque hit is the last assignment and wins
  always_comb begin
    sel_rgb = i_bg_rgb;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit1_q[i] && opaque[i]) sel_rgb = i_rom_data[i*12 +: 12];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_en_q     <= '0;
      sh_blink_q  <= '0;
      sh_x0_q     <= '0;
      sh_y0_q     <= '0;
      frame_cnt_q <= '0;
      rom_addr_q  <= '0;
      hit0_q      <= '0;
      hit1_q      <= '0;
      de0_q       <= 1'b0;
      de1_q       <= 1'b0;
      de_q        <= 1'b0;
      rgb_q       <= 12'h000;
    end else if (i_pix_ce) begin
      if (frame_start) begin
        sh_en_q     <= i_spr_en;
        sh_blink_q  <= i_spr_blink;
        sh_x0_q     <= i_spr_x0;
        sh_y0_q     <= i_spr_y0;
        frame_cnt_q <= frame_cnt_q + BLINK_LOG2'(1);
      end
      rom_addr_q <= rom_addr_d;
      hit0_q     <= hit;
      de0_q      <= i_de;
      hit1_q     <= hit0_q;
      de1_q      <= de0_q;
      rgb_q      <= de1_q ? sel_rgb : 12'h000;
      de_q       <= de1_q;
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_red      = rgb_q[11:8];
  assign o_green    = rgb_q[7:4];
  assign o_blue     = rgb_q[3:0];
  assign o_de       = de_q;

endmodule

// File: doc/sprite_overlay_compositor.md
Name: sprite_overlay_compositor

Overview:
- Parametrised successor of the fixed fire/warning image generator.
- Composites NUM_SPR rectangular ROM-backed sprites over a background colour for the VGA pixel stream.
- Sprite positions are programmable and latched per frame. Optional per-sprite blink.
- ROM addresses are derived from (x,y) rather than free-running counters, so mid-frame enable changes cannot desynchronise the image.
- Sits between the VGA timing generator (i_x/i_y/i_de) and the RGB output pins; the sprite block RAMs live outside the block.

Parameters:
- NUM_SPR, 2, number of sprite windows; index 0 has highest priority.
- SPR_W, 120, sprite width in pixels.
- SPR_H, 120, sprite height in pixels.
- X_W, 11, x coordinate width.
- Y_W, 10, y coordinate width.
- ADDR_W, 17, ROM address width per sprite; must satisfy SPR_W*SPR_H <= 2**ADDR_W.
- BLINK_LOG2, 5, blink half-period is 2**(BLINK_LOG2-1) frames.
- KEY_RGB, 12'hF0F, transparent colour key (used only with OVL_COLORKEY_EN).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_pix_ce  in  1  pixel clock enable; all state advances only when high.
- i_x  in  X_W  current pixel x.
- i_y  in  Y_W  current pixel y.
- i_de  in  1  active-video flag for i_x/i_y.
- i_spr_en  in  NUM_SPR  per-sprite enable.
- i_spr_blink  in  NUM_SPR  per-sprite blink request.
- i_spr_x0  in  NUM_SPR*X_W  sprite left edge, sprite i at [i*X_W +: X_W].
- i_spr_y0  in  NUM_SPR*Y_W  sprite top edge.
- i_bg_rgb  in  12  background colour {R,G,B}.
- o_rom_addr  out  NUM_SPR*ADDR_W  per-sprite ROM address.
- i_rom_data  in  NUM_SPR*12  per-sprite ROM data; 1-cycle read latency, ROM clocked on i_clk with enable = i_pix_ce.
- o_red  out  4  red.
- o_green  out  4  green.
- o_blue  out  4  blue.
- o_de  out  1  active-video flag aligned with RGB.

Behaviour:
- Reset (asynchronous, active-high): o_red/o_green/o_blue = 0, o_de = 0, o_rom_addr = 0, frame counter = 0, shadow en/blink/x0/y0 = 0 (all sprites hidden until the first frame start).
- Frame start: a ce cycle with i_x==0 && i_y==0.
  - On that cycle, shadow regs capture i_spr_en, i_spr_blink, i_spr_x0 and i_spr_y0.
  - On that cycle, the BLINK_LOG2-bit frame counter increments and wraps modulo 2**BLINK_LOG2.
  - Shadow values take effect from the next ce cycle. Input changes mid-frame have no effect until the next frame start.
- Visibility: vis[i] = sh_en[i] & ~(sh_blink[i] & frame_cnt[BLINK_LOG2-1]).
- Stage 0 (ce):
  - hit[i] = vis[i] & i_de & x0<=x<x0+SPR_W & y0<=y<y0+SPR_H.
  - Compare in X_W+1 / Y_W+1 bits so windows crossing the coordinate maximum do not wrap; off-screen parts are clipped.
  - Register o_rom_addr[i] = (y-y0)*SPR_W + (x-x0) when hit[i], else 0.
  - Register hit vector and de.
- Stage 1 (ce): ROM data is valid. Select the lowest-index hit sprite's data, else i_bg_rgb. Register de.
- Output register (ce): RGB = de ? selected : 12'h000. o_de = de.
- Total latency: i_x/i_y to RGB is 3 ce cycles; o_de is delayed identically.
- When i_pix_ce is low, every register holds.
- Overlapping windows: the lower index wins.
- Reset mid-frame: outputs go to 0 immediately; sprites stay hidden until the next frame start.

Optional Feature:
- OVL_COLORKEY_EN defined:
  - Sprite data equal to KEY_RGB counts as a miss for that sprite.
  - Selection falls through to the next-priority hit, then to the background.
  - The key comparison is done in stage 1; latency is unchanged.
- Not defined: every in-window pixel is opaque, and KEY_RGB is ignored.

Test Plan:
- Reset, then run 2 frames with no frame start reached before the check → RGB = 000 during active video even with i_spr_en=2'b11; o_de follows i_de delayed by 3.
- NUM_SPR=2, sprite0 at (521,1), ROM returns address LSBs, bg=12'h123 → at x=521,y=1 addr=0; at x=640,y=120 addr=14399; x=520 or x=641 shows 123.
- Sprites 0 and 1 both at (100,100) → sprite0 data wins; disable sprite0 mid-frame → change is visible only after the next (0,0).
- Sprite with x0=600 (X_W=11, SPR_W=120) → pixels 600–639 are drawn, no wrap at x=0–79, addr row stride stays 120.
- Blink=1, BLINK_LOG2=2 → sprite visible for frames where frame_cnt[1]=0, i.e. 2 frames on, 2 frames off, repeating.
- OVL_COLORKEY_EN, sprite0 returns F0F over sprite1 data 0A0 → output 0A0; without the macro → F0F.
